seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for an 8-digit common-select 7-segment display. Holds an 8-entry digit register file, steps a 3-bit digit index through all 8 positions with programmable on-time and inter-digit blanking, and drives the index into the existing 3-to-8 digit-select decoder (decoder_8) plus the segment pattern for the current digit. Sits between the bus/register write side and the display pins.

---
 rtl/seg_scan_ctrl_pkg.sv | 28 ++
 rtl/seg_scan_ctrl_if.sv | 12 +
 rtl/seg_scan_ctrl_hex_to_seg7.sv | 11 +
 rtl/seg_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the 8-digit 7-segment scan controller.
package seg_scan_ctrl_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned VAL_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_e;

  // One register-file entry: decimal point plus hex value.
  typedef struct packed {
    logic             dp;
    logic [VAL_W-1:0] val;
  } digit_t;

  // Active-high a..g patterns (bit0 = a), indexed by hex value 0x0..0xF.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Write side of the digit register file.
interface seg_scan_ctrl_if;
  import seg_scan_ctrl_pkg::*;

  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [VAL_W-1:0] wr_data;
  logic             wr_dp;

  modport master (output wr_en, output wr_addr, output wr_data, output wr_dp);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  wr_dp);
endinterface

// File: rtl/seg_scan_ctrl_hex_to_seg7.sv
// Hex value to active-high 7-segment pattern, purely combinational.
module hex_to_seg7
  import seg_scan_ctrl_pkg::*;
(
  input  logic [VAL_W-1:0] val,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = SEG_TABLE[val];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller: 8-entry digit register file, show/blank
// slot timing and registered digit-select / segment outputs.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES  = 1000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_en,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  seg_scan_ctrl_if.slave        wr_bus,
  output logic [IDX_W-1:0]      dig_sel,
  output logic                  dig_on,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam bit               HAS_BLANK  = (BLANK_CYCLES != 0);
  localparam logic [CNT_W-1:0] BLANK_LAST = HAS_BLANK ? CNT_W'(BLANK_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_t           mem_q [NUM_DIGITS];
  digit_t           mem_d [NUM_DIGITS];
  logic             dig_on_q, dig_on_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  logic             advance;
  logic             lit;
  digit_t           cur_digit;
  logic [SEG_W-1:0] cur_seg;

  // Register file write port; usable in every scan state.
  always_comb begin
    mem_d = mem_q;
    if (wr_bus.wr_en) begin
      mem_d[wr_bus.wr_addr].dp  = wr_bus.wr_dp;
      mem_d[wr_bus.wr_addr].val = wr_bus.wr_data;
    end
  end

  // Register file storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Outputs are computed from the next index so dig_sel and segments change together.
  assign cur_digit = mem_q[idx_d];

  hex_to_seg7 u_hex_to_seg7 (
    .val   (cur_digit.val),
    .seg_c (cur_seg)
  );

  // Next-state, slot timing and next output values.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    advance      = 1'b0;
    lit          = 1'b0;
    dig_on_d     = 1'b0;
    seg_d        = '0;
    dp_d         = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (scan_en) state_d = SHOW;
      end
      SHOW: begin
        if (!scan_en) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == SHOW_LAST) begin
          cnt_d = '0;
          if (HAS_BLANK) state_d = BLANK;
          else           advance = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BLANK: begin
        if (!scan_en) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          advance = 1'b1;
          state_d = SHOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    if (advance) begin
      idx_d        = idx_q + IDX_W'(1);
      frame_done_d = (idx_q == IDX_W'(NUM_DIGITS - 1));
    end

    lit      = (state_d == SHOW) && digit_mask[idx_d];
    dig_on_d = lit;
    seg_d    = lit ? cur_seg : '0;
    dp_d     = lit ? cur_digit.dp : 1'b0;
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      dig_on_q     <= 1'b0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      dig_on_q     <= dig_on_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dig_sel    = idx_q;
  assign dig_on     = dig_on_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: one instance with SHOW=4/BLANK=1, one with SHOW=1/BLANK=0.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scan_en, scan_en_b;
  logic [7:0] digit_mask;

  logic [2:0] dig_sel, dig_sel_b;
  logic       dig_on, dig_on_b;
  logic [6:0] seg, seg_b;
  logic       dp, dp_b;
  logic       frame_done, frame_done_b;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl_if wr_if_a ();
  seg_scan_ctrl_if wr_if_b ();

  seg_scan_ctrl #(.SHOW_CYCLES(4), .BLANK_CYCLES(1)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_en    (scan_en),
    .digit_mask (digit_mask),
    .wr_bus     (wr_if_a),
    .dig_sel    (dig_sel),
    .dig_on     (dig_on),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  seg_scan_ctrl #(.SHOW_CYCLES(1), .BLANK_CYCLES(0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_en    (scan_en_b),
    .digit_mask (8'hFF),
    .wr_bus     (wr_if_b),
    .dig_sel    (dig_sel_b),
    .dig_on     (dig_on_b),
    .seg        (seg_b),
    .dp         (dp_b),
    .frame_done (frame_done_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mask;
    int         slot;
    logic       on;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  vec_t vecs [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Park in IDLE for one cycle, then enable; the next step() is scan cycle 1.
  task automatic restart(input logic [7:0] m);
    scan_en = 1'b0;
    step();
    digit_mask = m;
    scan_en    = 1'b1;
  endtask

  initial begin
    int slot, pos;
    logic on_e;

    // Expected per-slot readings with entries 0..7 = 0..7 and dp only on entry 3.
    vecs[0]  = '{8'hFF, 0, 1'b1, 7'h3F, 1'b0};
    vecs[1]  = '{8'hFF, 1, 1'b1, 7'h06, 1'b0};
    vecs[2]  = '{8'hFF, 2, 1'b1, 7'h5B, 1'b0};
    vecs[3]  = '{8'hFF, 3, 1'b1, 7'h4F, 1'b1};
    vecs[4]  = '{8'hFF, 4, 1'b1, 7'h66, 1'b0};
    vecs[5]  = '{8'hFF, 5, 1'b1, 7'h6D, 1'b0};
    vecs[6]  = '{8'hFF, 6, 1'b1, 7'h7D, 1'b0};
    vecs[7]  = '{8'hFF, 7, 1'b1, 7'h07, 1'b0};
    vecs[8]  = '{8'hAA, 0, 1'b0, 7'h00, 1'b0};
    vecs[9]  = '{8'hAA, 1, 1'b1, 7'h06, 1'b0};
    vecs[10] = '{8'hAA, 2, 1'b0, 7'h00, 1'b0};
    vecs[11] = '{8'hAA, 3, 1'b1, 7'h4F, 1'b1};
    vecs[12] = '{8'hAA, 4, 1'b0, 7'h00, 1'b0};
    vecs[13] = '{8'hAA, 5, 1'b1, 7'h6D, 1'b0};
    vecs[14] = '{8'hAA, 6, 1'b0, 7'h00, 1'b0};
    vecs[15] = '{8'hAA, 7, 1'b1, 7'h07, 1'b0};

    rst_n          = 1'b0;
    scan_en        = 1'b0;
    scan_en_b      = 1'b0;
    digit_mask     = 8'hFF;
    wr_if_a.wr_en  = 1'b0; wr_if_a.wr_addr = '0; wr_if_a.wr_data = '0; wr_if_a.wr_dp = 1'b0;
    wr_if_b.wr_en  = 1'b0; wr_if_b.wr_addr = '0; wr_if_b.wr_data = '0; wr_if_b.wr_dp = 1'b0;

    // Reset state
    #2;
    chk("rst_dig_sel", dig_sel, 0);
    chk("rst_dig_on", dig_on, 0);
    chk("rst_seg", seg, 0);
    chk("rst_dp", dp, 0);
    chk("rst_frame_done", frame_done, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("idle_dig_on", dig_on, 0);
    chk("idle_seg", seg, 0);

    // First frame, all entries 0x0: 5-clock slots, 4 lit, frame_done at cycle 41 only
    scan_en = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      step();
      slot = (k - 1) / 5;
      pos  = (k - 1) % 5;
      on_e = (pos < 4);
      chk("f1_dig_sel", dig_sel, slot % 8);
      chk("f1_dig_on", dig_on, on_e);
      chk("f1_seg", seg, on_e ? 7'h3F : 7'h00);
      chk("f1_frame_done", frame_done, (k == 41));
    end

    // Load entries 0..7 = 0..7, dp on 3, while idle
    scan_en = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      wr_if_a.wr_en   = 1'b1;
      wr_if_a.wr_addr = 3'(i);
      wr_if_a.wr_data = 4'(i);
      wr_if_a.wr_dp   = (i == 3);
      step();
    end
    wr_if_a.wr_en = 1'b0;

    // Table: mid-show and blank reading of each slot under two masks
    for (int v = 0; v < 16; v++) begin
      restart(vecs[v].mask);
      repeat (5 * vecs[v].slot + 2) step();
      chk("tbl_dig_sel", dig_sel, vecs[v].slot);
      chk("tbl_dig_on", dig_on, vecs[v].on);
      chk("tbl_seg", seg, vecs[v].seg);
      chk("tbl_dp", dp, vecs[v].dp);
      repeat (3) step();
      chk("tbl_blank_sel", dig_sel, vecs[v].slot);
      chk("tbl_blank_on", dig_on, 0);
      chk("tbl_blank_seg", seg, 0);
    end

    // Masked slots keep timing: frame period stays 40 clocks
    restart(8'hAA);
    for (int k = 1; k <= 81; k++) begin
      step();
      chk("mask_frame_done", frame_done, (k == 41 || k == 81));
    end

    // Write to the lit digit shows one cycle after the write edge
    restart(8'hFF);
    repeat (2) step();
    chk("wr_before", seg, 7'h3F);
    wr_if_a.wr_en = 1'b1; wr_if_a.wr_addr = 3'd0; wr_if_a.wr_data = 4'h8; wr_if_a.wr_dp = 1'b0;
    step();
    wr_if_a.wr_en = 1'b0;
    chk("wr_same_cycle", seg, 7'h3F);
    step();
    chk("wr_visible", seg, 7'h7F);

    // Abort mid-slot 5, then restart from slot 0 with no stray frame_done
    restart(8'hFF);
    repeat (27) step();
    chk("abort_pre_sel", dig_sel, 5);
    chk("abort_pre_on", dig_on, 1);
    scan_en = 1'b0;
    step();
    chk("abort_sel", dig_sel, 0);
    chk("abort_on", dig_on, 0);
    chk("abort_seg", seg, 0);
    chk("abort_frame_done", frame_done, 0);
    scan_en = 1'b1;
    for (int k = 1; k <= 41; k++) begin
      step();
      if (k == 1) begin
        chk("reen_sel", dig_sel, 0);
        chk("reen_on", dig_on, 1);
      end
      chk("reen_frame_done", frame_done, (k == 41));
    end

    // No blanking, one-clock slots: index steps every clock
    scan_en_b = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      chk("nb_dig_sel", dig_sel_b, (k - 1) % 8);
      chk("nb_dig_on", dig_on_b, 1);
      chk("nb_seg", seg_b, 7'h3F);
      chk("nb_frame_done", frame_done_b, (k == 9 || k == 17));
    end
    scan_en_b = 1'b0;

    // Async reset mid-show of slot 2 clears outputs and the register file
    scan_en = 1'b0;
    step();
    wr_if_a.wr_en = 1'b1; wr_if_a.wr_addr = 3'd2; wr_if_a.wr_data = 4'hA; wr_if_a.wr_dp = 1'b0;
    step();
    wr_if_a.wr_en = 1'b0;
    digit_mask = 8'hFF;
    scan_en    = 1'b1;
    repeat (12) step();
    chk("pre_rst_sel", dig_sel, 2);
    chk("pre_rst_seg", seg, 7'h77);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel", dig_sel, 0);
    chk("arst_on", dig_on, 0);
    chk("arst_seg", seg, 0);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("post_rst_slot0_sel", dig_sel, 0);
    chk("post_rst_slot0_seg", seg, 7'h3F);
    repeat (10) step();
    chk("post_rst_sel", dig_sel, 2);
    chk("post_rst_on", dig_on, 1);
    chk("post_rst_seg", seg, 7'h3F);
    chk("post_rst_dp", dp, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
